// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path.
// Holds the 2-bit counter encoding, the BTB entry field layout helpers,
// the default index width and the counter reset/allocate values.
package btb_pkg;

  localparam int INDEX_W_DEF = 10;
  localparam int PC_W        = 32;
  localparam int TARGET_W    = 32;
  localparam int CNT_W       = 2;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,  // strong not-taken
    CNT_WNT = 2'b01,  // weak not-taken
    CNT_WT  = 2'b10,  // weak taken
    CNT_ST  = 2'b11   // strong taken
  } cnt_e;

  localparam cnt_e CNT_RST   = CNT_SNT;
  localparam cnt_e CNT_ALLOC = CNT_WT;

  // Entry layout (LSB first): target, tag, valid, counter.
  localparam int TARGET_LSB = 0;
  localparam int TAG_LSB    = TARGET_W;

  function automatic int tag_w(input int index_w);
    return PC_W - 2 - index_w;
  endfunction

  function automatic int valid_pos(input int index_w);
    return TAG_LSB + tag_w(index_w);
  endfunction

  function automatic int cnt_lsb(input int index_w);
    return valid_pos(index_w) + 1;
  endfunction

  function automatic int entry_w(input int index_w);
    return cnt_lsb(index_w) + CNT_W;
  endfunction

  localparam int ENTRY_W_DEF = entry_w(INDEX_W_DEF);

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating branch counter next-state logic.
// Latency: combinational. Backpressure: none.
// Taken moves toward strong-taken, not-taken toward strong-not-taken.
module sat_counter2
  import btb_pkg::*;
(
  input  cnt_e cnt,
  input  logic taken,
  output cnt_e next_cnt
);

  // Saturating step in the resolved direction
  always_comb begin
    next_cnt = cnt;
    unique case (cnt)
      CNT_SNT: next_cnt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: next_cnt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  next_cnt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  next_cnt = taken ? CNT_ST  : CNT_WT;
      default: next_cnt = cnt;
    endcase
  end

endmodule

// File: rtl/btb_update.sv
// BTB update from EX: computes redirect/mispredict and writes back the entry.
// Latency: redirect/mispredict combinational; BTB write registered, 1 cycle after resolution.
// Backpressure: i_ex_stall holds the instruction; no update until released. Perf counters: BTB_PERF_CNT_EN.
module btb_update
  import btb_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_ex_valid,
  input  logic                        i_ex_is_branch,
  input  logic                        i_ex_stall,
  input  logic [31:0]                 i_ex_pc,
  input  logic                        i_ex_taken,
  input  logic [31:0]                 i_ex_target,
  input  logic [2:0]                  i_ex_predict,
  input  logic [31:0]                 i_ex_pc_predicted,
  output logic                        o_btb_wren,
  output logic [31:0]                 o_btb_addr,
  output logic [entry_w(INDEX_W)-1:0] o_btb_data,
  output logic                        o_mispredict,
  output logic [31:0]                 o_redirect_pc,
  output logic [31:0]                 o_branch_cnt,
  output logic [31:0]                 o_mispred_cnt
);

  localparam int TAG_W   = tag_w(INDEX_W);
  localparam int ENTRY_W = entry_w(INDEX_W);

  logic        update;
  logic        fwd_hit;
  logic        hit;
  cnt_e        prior_cnt;
  cnt_e        next_cnt;
  cnt_e        wr_cnt;
  logic        do_write;
  logic [TAG_W-1:0] tag;

  // Most recent write, used to bypass a stale fetch-time BTB read
  logic        lw_valid;
  logic [31:0] lw_pc;
  cnt_e        lw_cnt;

  assign update  = i_ex_valid & i_ex_is_branch & ~i_ex_stall;
  assign fwd_hit = lw_valid & (lw_pc == i_ex_pc);
  assign tag     = i_ex_pc[31:INDEX_W+2];

  // Pick the prior counter state, preferring the in-flight write over the fetch read
  always_comb begin
    prior_cnt = cnt_e'(i_ex_predict[2:1]);
    hit       = i_ex_predict[0];
    if (fwd_hit) begin
      prior_cnt = lw_cnt;
      hit       = 1'b1;
    end
  end

  sat_counter2 u_sat_counter2 (
    .cnt      (prior_cnt),
    .taken    (i_ex_taken),
    .next_cnt (next_cnt)
  );

  // Hits update the counter; taken misses allocate; not-taken misses are dropped
  always_comb begin
    do_write = update & (hit | i_ex_taken);
    wr_cnt   = hit ? next_cnt : CNT_ALLOC;
  end

  // Correct next-PC and flush request for the resolving branch
  always_comb begin
    o_redirect_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
    o_mispredict  = update & (o_redirect_pc != i_ex_pc_predicted);
  end

  // Registered BTB write port and last-write bypass register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_btb_wren <= 1'b0;
      o_btb_addr <= '0;
      o_btb_data <= '0;
      lw_valid   <= 1'b0;
      lw_pc      <= '0;
      lw_cnt     <= CNT_RST;
    end else begin
      o_btb_wren <= do_write;
      if (do_write) begin
        o_btb_addr <= i_ex_pc;
        o_btb_data <= ENTRY_W'({wr_cnt, 1'b1, tag, i_ex_target});
        lw_valid   <= 1'b1;
        lw_pc      <= i_ex_pc;
        lw_cnt     <= wr_cnt;
      end
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  // Resolved-branch and mispredict event counters, free-running with wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (update) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (o_mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign o_branch_cnt  = branch_cnt;
  assign o_mispred_cnt = mispred_cnt;
`else
  assign o_branch_cnt  = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule
